color_blend_seq: RTL and testbench



---
 rtl/color_blend_seq.sv | 201 ++++++++++++++++++++
 tb/tb_color_blend_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_blend_seq.sv
`timescale 1ns/1ps
// color_blend_seq: blends a stored pixel with a brush pixel (subtract-mix, add-sat, average, replace).
// Latency: 2 cycles from request to o_valid; COLOR_W+2 when the subtractive mix must be normalised.
// Backpressure: one request in flight; o_ready stays low until the held result is taken by i_out_ready.
module color_blend_seq #(
  parameter int COLOR_W = 5,
  parameter int CNT_W   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_mode,
  input  logic [COLOR_W-1:0] i_sdram_R,
  input  logic [COLOR_W-1:0] i_sdram_G,
  input  logic [COLOR_W-1:0] i_sdram_B,
  input  logic [COLOR_W-1:0] i_draw_R,
  input  logic [COLOR_W-1:0] i_draw_G,
  input  logic [COLOR_W-1:0] i_draw_B,
  output logic               o_valid,
  input  logic               i_out_ready,
  output logic [COLOR_W-1:0] o_draw_R,
  output logic [COLOR_W-1:0] o_draw_G,
  output logic [COLOR_W-1:0] o_draw_B
);

  localparam int AW = COLOR_W + 1;
  localparam int NW = 2 * COLOR_W + 1;
  localparam logic [COLOR_W-1:0] MAX  = {COLOR_W{1'b1}};
  localparam logic [CNT_W-1:0]   LAST = CNT_W'(COLOR_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DIV, S_DONE} state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_valid;
  logic [1:0]         r_mode;
  logic [COLOR_W-1:0] r_sdram_R, r_sdram_G, r_sdram_B;
  logic [COLOR_W-1:0] r_draw_R, r_draw_G, r_draw_B;
  logic [COLOR_W-1:0] r_out_R, r_out_G, r_out_B;
  logic [1:0]         r_lead;
  logic [AW-1:0]      r_m;
  logic [AW-1:0]      r_rem0, r_rem1;
  logic [COLOR_W-1:0] r_num0, r_num1;
  // Quotient bits collected so far; the last bit is appended combinationally.
  logic [COLOR_W-2:0] r_q0, r_q1;
  logic [CNT_W-1:0]   r_cnt;

  logic [AW-1:0]      w_a_R, w_a_G, w_a_B, w_m, w_d0, w_d1;
  logic [1:0]         w_lead;
  logic [NW-1:0]      w_n0, w_n1;
  logic [AW-1:0]      w_s_R, w_s_G, w_s_B;
  logic [COLOR_W-1:0] w_sat_R, w_sat_G, w_sat_B;
  logic [AW:0]        w_t0, w_t1;
  logic               w_ge0, w_ge1;
  logic [AW-1:0]      w_rem0n, w_rem1n;
  logic [COLOR_W-1:0] w_fq0, w_fq1;

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_draw_R = r_out_R;
  assign o_draw_G = r_out_G;
  assign o_draw_B = r_out_B;

  // Per-mode arithmetic on the latched request plus one restoring-divider step per channel.
  always_comb begin
    w_a_R = {1'b0, MAX - r_sdram_R} + {1'b0, MAX - r_draw_R};
    w_a_G = {1'b0, MAX - r_sdram_G} + {1'b0, MAX - r_draw_G};
    w_a_B = {1'b0, MAX - r_sdram_B} + {1'b0, MAX - r_draw_B};
    w_m = w_a_R;
    if (w_a_G > w_m) w_m = w_a_G;
    if (w_a_B > w_m) w_m = w_a_B;
    // Ties resolve towards R, then G.
    if (w_a_R == w_m)      w_lead = 2'd0;
    else if (w_a_G == w_m) w_lead = 2'd1;
    else                   w_lead = 2'd2;
    case (w_lead)
      2'd0:    begin w_d0 = w_a_G; w_d1 = w_a_B; end
      2'd1:    begin w_d0 = w_a_R; w_d1 = w_a_B; end
      default: begin w_d0 = w_a_R; w_d1 = w_a_G; end
    endcase
    w_n0 = {{COLOR_W{1'b0}}, w_d0} * {{AW{1'b0}}, MAX};
    w_n1 = {{COLOR_W{1'b0}}, w_d1} * {{AW{1'b0}}, MAX};

    w_s_R   = {1'b0, r_sdram_R} + {1'b0, r_draw_R};
    w_s_G   = {1'b0, r_sdram_G} + {1'b0, r_draw_G};
    w_s_B   = {1'b0, r_sdram_B} + {1'b0, r_draw_B};
    w_sat_R = (w_s_R > {1'b0, MAX}) ? MAX : w_s_R[COLOR_W-1:0];
    w_sat_G = (w_s_G > {1'b0, MAX}) ? MAX : w_s_G[COLOR_W-1:0];
    w_sat_B = (w_s_B > {1'b0, MAX}) ? MAX : w_s_B[COLOR_W-1:0];

    // Partial remainder stays below the divisor, so the trial value is below 2*m.
    w_t0    = {r_rem0, r_num0[COLOR_W-1]};
    w_t1    = {r_rem1, r_num1[COLOR_W-1]};
    w_ge0   = (w_t0 >= {1'b0, r_m});
    w_ge1   = (w_t1 >= {1'b0, r_m});
    w_rem0n = w_ge0 ? (w_t0[AW-1:0] - r_m) : w_t0[AW-1:0];
    w_rem1n = w_ge1 ? (w_t1[AW-1:0] - r_m) : w_t1[AW-1:0];
    w_fq0   = {r_q0, w_ge0};
    w_fq1   = {r_q1, w_ge1};
  end

  // Control FSM with registered handshake and pixel outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_mode    <= '0;
      r_sdram_R <= '0; r_sdram_G <= '0; r_sdram_B <= '0;
      r_draw_R  <= '0; r_draw_G  <= '0; r_draw_B  <= '0;
      r_out_R   <= '0; r_out_G   <= '0; r_out_B   <= '0;
      r_lead    <= '0;
      r_m       <= '0;
      r_rem0    <= '0; r_rem1 <= '0;
      r_num0    <= '0; r_num1 <= '0;
      r_q0      <= '0; r_q1   <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid && r_ready) begin
            r_mode    <= i_mode;
            r_sdram_R <= i_sdram_R; r_sdram_G <= i_sdram_G; r_sdram_B <= i_sdram_B;
            r_draw_R  <= i_draw_R;  r_draw_G  <= i_draw_G;  r_draw_B  <= i_draw_B;
            r_ready   <= 1'b0;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_mode == 2'd0 && w_m > {1'b0, MAX}) begin
            // Mix overflows the channel range: rescale so the leader hits MAX.
            r_lead  <= w_lead;
            r_m     <= w_m;
            r_rem0  <= w_n0[NW-1:COLOR_W];
            r_rem1  <= w_n1[NW-1:COLOR_W];
            r_num0  <= w_n0[COLOR_W-1:0];
            r_num1  <= w_n1[COLOR_W-1:0];
            r_q0    <= '0;
            r_q1    <= '0;
            r_cnt   <= '0;
            r_state <= S_DIV;
          end else begin
            case (r_mode)
              2'd0: begin
                r_out_R <= MAX - w_a_R[COLOR_W-1:0];
                r_out_G <= MAX - w_a_G[COLOR_W-1:0];
                r_out_B <= MAX - w_a_B[COLOR_W-1:0];
              end
              2'd1: begin
                r_out_R <= w_sat_R; r_out_G <= w_sat_G; r_out_B <= w_sat_B;
              end
              2'd2: begin
                r_out_R <= w_s_R[AW-1:1]; r_out_G <= w_s_G[AW-1:1]; r_out_B <= w_s_B[AW-1:1];
              end
              default: begin
                r_out_R <= r_draw_R; r_out_G <= r_draw_G; r_out_B <= r_draw_B;
              end
            endcase
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DIV: begin
          r_rem0 <= w_rem0n;
          r_rem1 <= w_rem1n;
          r_num0 <= {r_num0[COLOR_W-2:0], 1'b0};
          r_num1 <= {r_num1[COLOR_W-2:0], 1'b0};
          r_q0   <= w_fq0[COLOR_W-2:0];
          r_q1   <= w_fq1[COLOR_W-2:0];
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            // Leader is pinned to MAX, so its subtractive output is zero.
            case (r_lead)
              2'd0: begin
                r_out_R <= '0; r_out_G <= MAX - w_fq0; r_out_B <= MAX - w_fq1;
              end
              2'd1: begin
                r_out_R <= MAX - w_fq0; r_out_G <= '0; r_out_B <= MAX - w_fq1;
              end
              default: begin
                r_out_R <= MAX - w_fq0; r_out_G <= MAX - w_fq1; r_out_B <= '0;
              end
            endcase
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_blend_seq.sv
`timescale 1ns/1ps
// Directed and randomised checks of color_blend_seq through a result scoreboard.
module tb_color_blend_seq;

  localparam int W    = 5;
  localparam int MAXV = (1 << W) - 1;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic [7:0]   lat;
  } exp_t;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [1:0]   i_mode;
  logic [W-1:0] i_sdram_R, i_sdram_G, i_sdram_B;
  logic [W-1:0] i_draw_R, i_draw_G, i_draw_B;
  logic         o_valid;
  logic         i_out_ready;
  logic [W-1:0] o_draw_R, o_draw_G, o_draw_B;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  always #5 i_clk = ~i_clk;

  color_blend_seq #(.COLOR_W(W), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
    .i_sdram_R(i_sdram_R), .i_sdram_G(i_sdram_G), .i_sdram_B(i_sdram_B),
    .i_draw_R(i_draw_R), .i_draw_G(i_draw_G), .i_draw_B(i_draw_B),
    .o_valid(o_valid), .i_out_ready(i_out_ready),
    .o_draw_R(o_draw_R), .o_draw_G(o_draw_G), .o_draw_B(o_draw_B)
  );

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int r, input int g, input int b, input int lat);
    exp_t e;
    e.r = W'(r); e.g = W'(g); e.b = W'(b); e.lat = 8'(lat);
    return e;
  endfunction

  // Reference: plain integer arithmetic, division by the built-in operator.
  function automatic exp_t model(input int mode, input int sr, input int sg, input int sb,
                                 input int dr, input int dg, input int db);
    int s[3], d[3], a[3], res[3];
    int m, lead, lat;
    s[0] = sr; s[1] = sg; s[2] = sb;
    d[0] = dr; d[1] = dg; d[2] = db;
    lat = 2;
    for (int i = 0; i < 3; i++) begin
      case (mode)
        0: a[i] = (MAXV - s[i]) + (MAXV - d[i]);
        1: res[i] = (s[i] + d[i] > MAXV) ? MAXV : s[i] + d[i];
        2: res[i] = (s[i] + d[i]) / 2;
        default: res[i] = d[i];
      endcase
    end
    if (mode == 0) begin
      m = a[0];
      if (a[1] > m) m = a[1];
      if (a[2] > m) m = a[2];
      lead = (a[0] == m) ? 0 : ((a[1] == m) ? 1 : 2);
      for (int i = 0; i < 3; i++) begin
        if (m > MAXV) res[i] = (i == lead) ? MAXV : (a[i] * MAXV) / m;
        else          res[i] = a[i];
        res[i] = MAXV - res[i];
      end
      if (m > MAXV) lat = W + 2;
    end
    return mk(res[0], res[1], res[2], lat);
  endfunction

  task automatic present(input int mode, input int sr, input int sg, input int sb,
                         input int dr, input int dg, input int db, input bit push, input exp_t e);
    i_mode    = 2'(mode);
    i_sdram_R = W'(sr); i_sdram_G = W'(sg); i_sdram_B = W'(sb);
    i_draw_R  = W'(dr); i_draw_G  = W'(dg); i_draw_B  = W'(db);
    i_valid   = 1'b1;
    if (push) sb_q.push_back(e);
  endtask

  // Accepts the presented request, scrambles inputs, waits for o_valid and scores it.
  task automatic collect(input string tag);
    int   lat;
    exp_t e;
    tick;
    lat = 1;
    i_valid = 1'b0;
    i_sdram_R = W'($urandom); i_sdram_G = W'($urandom); i_sdram_B = W'($urandom);
    i_draw_R  = W'($urandom); i_draw_G  = W'($urandom); i_draw_B  = W'($urandom);
    i_mode    = 2'($urandom);
    check({tag, "_busy"}, 32'(o_ready), 32'd0);
    while (!o_valid && lat < 40) begin
      tick;
      lat++;
    end
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_sb"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_lat"}, 32'(lat), 32'(e.lat));
      check({tag, "_R"}, 32'(o_draw_R), 32'(e.r));
      check({tag, "_G"}, 32'(o_draw_G), 32'(e.g));
      check({tag, "_B"}, 32'(o_draw_B), 32'(e.b));
    end
  endtask

  task automatic release_result(input string tag);
    tick;
    check({tag, "_vdrop"}, 32'(o_valid), 32'd0);
    check({tag, "_rdy"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int md, sr, sg, sb, dr, dg, db;
    i_rst = 1'b1; i_valid = 1'b0; i_out_ready = 1'b1; i_mode = 2'd0;
    i_sdram_R = '0; i_sdram_G = '0; i_sdram_B = '0;
    i_draw_R  = '0; i_draw_G  = '0; i_draw_B  = '0;
    #2;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_R", 32'(o_draw_R), 32'd0);
    check("rst_G", 32'(o_draw_G), 32'd0);
    check("rst_B", 32'(o_draw_B), 32'd0);
    tick; tick;
    i_rst = 1'b0;
    tick;

    present(0, 0, 31, 31, 31, 0, 31, 1'b1, mk(0, 0, 31, 2));
    collect("sub_noscale");
    release_result("sub_noscale");

    present(0, 0, 0, 31, 0, 31, 31, 1'b1, mk(0, 16, 31, 7));
    collect("sub_scale");
    release_result("sub_scale");

    present(0, 0, 0, 0, 0, 0, 0, 1'b1, mk(0, 0, 0, 7));
    collect("sub_tie");
    release_result("sub_tie");

    present(2, 3, 4, 31, 0, 4, 30, 1'b1, mk(1, 4, 30, 2));
    collect("avg");
    release_result("avg");

    present(3, 1, 2, 3, 7, 8, 9, 1'b1, mk(7, 8, 9, 2));
    collect("repl");
    release_result("repl");

    // Result held under backpressure while another request waits.
    i_out_ready = 1'b0;
    present(1, 20, 5, 31, 20, 5, 1, 1'b1, mk(31, 10, 31, 2));
    collect("bp");
    present(3, 9, 9, 9, 1, 2, 3, 1'b1, mk(1, 2, 3, 2));
    for (int i = 0; i < 10; i++) begin
      tick;
      check("bp_hold_valid", 32'(o_valid), 32'd1);
      check("bp_hold_rdy", 32'(o_ready), 32'd0);
      check("bp_hold_R", 32'(o_draw_R), 32'd31);
      check("bp_hold_G", 32'(o_draw_G), 32'd10);
      check("bp_hold_B", 32'(o_draw_B), 32'd31);
    end
    i_out_ready = 1'b1;
    tick;
    check("bp_rel_valid", 32'(o_valid), 32'd0);
    check("bp_rel_rdy", 32'(o_ready), 32'd1);
    collect("bp_next");
    release_result("bp_next");

    // Reset during the second divider cycle discards the in-flight result.
    present(0, 0, 0, 31, 0, 31, 31, 1'b0, mk(0, 0, 0, 0));
    tick;
    i_valid = 1'b0;
    tick; tick;
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_rdy", 32'(o_ready), 32'd1);
    check("mid_rst_R", 32'(o_draw_R), 32'd0);
    check("mid_rst_G", 32'(o_draw_G), 32'd0);
    check("mid_rst_B", 32'(o_draw_B), 32'd0);
    tick; tick;
    i_rst = 1'b0;
    tick;
    present(0, 0, 0, 31, 0, 31, 31, 1'b1, mk(0, 16, 31, 7));
    collect("post_rst");
    release_result("post_rst");

    for (int i = 0; i < 12; i++) begin
      md = i % 4;
      sr = $urandom_range(0, MAXV); sg = $urandom_range(0, MAXV); sb = $urandom_range(0, MAXV);
      dr = $urandom_range(0, MAXV); dg = $urandom_range(0, MAXV); db = $urandom_range(0, MAXV);
      present(md, sr, sg, sb, dr, dg, db, 1'b1, model(md, sr, sg, sb, dr, dg, db));
      collect("rand");
      release_result("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
